// File: rtl/alt_vipvfr131_common_sched_pkg.sv
// rtl/alt_vipvfr131_common_sched_pkg.sv - shared types and helpers for the frame-read burst scheduler
package alt_vipvfr131_common_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_ISSUE = 2'd2,
        S_DRAIN = 2'd3
    } sched_state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int x;
        r = 0;
        x = value - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >>> 1;
        end
        return r;
    endfunction

    // Byte-to-word shift for a given master data width (width/8 is a power of two).
    function automatic int word_shift(input int data_width);
        return clog2(data_width / 8);
    endfunction

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_SHIFT     = clog2(BYTES_PER_WORD);

endpackage

// File: rtl/alt_vipvfr131_common_credit_counter.sv
// rtl/alt_vipvfr131_common_credit_counter.sv - outstanding read word counter with fit check
module alt_vipvfr131_common_credit_counter
    import alt_vipvfr131_common_sched_pkg::*;
#(
    parameter int CREDIT_DEPTH = 64,
    parameter int LEN_WIDTH    = 11,
    parameter int CW           = clog2(CREDIT_DEPTH + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 accept,
    input  logic [LEN_WIDTH-1:0] accept_len,
    input  logic                 data_read,
    input  logic [LEN_WIDTH-1:0] check_len,
    output logic [CW-1:0]        outstanding,
    output logic                 fits
);

    logic [CW-1:0] add_amt;
    logic [CW-1:0] sub_amt;
    logic [CW-1:0] count_next;

    // Next count: add an accepted burst, return one credit per consumed word, never below zero.
    // The fit check looks at this post-edge value so a freshly returned credit counts immediately.
    always_comb begin
        add_amt    = accept ? CW'(accept_len) : '0;
        sub_amt    = (data_read && (outstanding != '0)) ? CW'(1) : '0;
        count_next = outstanding + add_amt - sub_amt;
        fits       = (32'(count_next) + 32'(check_len)) <= 32'(CREDIT_DEPTH);
    end

    // Counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            outstanding <= count_next;
        end
    end

endmodule

// File: rtl/alt_vipvfr131_common_read_burst_scheduler.sv
// rtl/alt_vipvfr131_common_read_burst_scheduler.sv - walks a frame region issuing credit-limited read bursts
module alt_vipvfr131_common_read_burst_scheduler
    import alt_vipvfr131_common_sched_pkg::*;
#(
    parameter int ADDR_WIDTH                     = 32,
    parameter int DATA_WIDTH                     = 32,
    parameter int MAX_BURST_LENGTH_REQUIREDWIDTH = 11,
    parameter int TARGET_BURST_SIZE              = 32,
    parameter int CREDIT_DEPTH                   = 64,
    parameter int LINE_WIDTH                     = 16
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      go,
    input  logic [ADDR_WIDTH-1:0]                     base_addr,
    input  logic [ADDR_WIDTH-1:0]                     line_stride,
    input  logic [LINE_WIDTH-1:0]                     words_per_line,
    input  logic [LINE_WIDTH-1:0]                     num_lines,
    output logic                                      busy,
    output logic                                      done,
    output logic [ADDR_WIDTH-1:0]                     cmd_addr,
    output logic                                      cmd_command,
    output logic                                      cmd_is_burst,
    output logic                                      cmd_is_write_not_read,
    output logic [MAX_BURST_LENGTH_REQUIREDWIDTH-1:0] cmd_burst_length,
    input  logic                                      stall,
    input  logic                                      data_read
);

    localparam int WSHIFT = word_shift(DATA_WIDTH);
    localparam int BLW    = MAX_BURST_LENGTH_REQUIREDWIDTH;
    localparam int CW     = clog2(CREDIT_DEPTH + 1);

    sched_state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] cfg_base, cfg_stride;
    logic [LINE_WIDTH-1:0] cfg_wpl, cfg_lines;
    logic [ADDR_WIDTH-1:0] line_addr, word_addr, nxt_line_addr, nxt_word_addr, len_bytes;
    logic [LINE_WIDTH-1:0] words_left, lines_left, nxt_words_left, nxt_lines_left;
    logic [BLW-1:0]        cur_len, nxt_len;
    logic [CW-1:0]         outstanding;
    logic                  accept, fits;

    function automatic logic [BLW-1:0] burst_len(input logic [LINE_WIDTH-1:0] left);
        if (32'(left) > 32'(TARGET_BURST_SIZE)) return BLW'(TARGET_BURST_SIZE);
        return BLW'(left);
    endfunction

    assign accept                = cmd_command && !stall;
    assign cur_len               = burst_len(words_left);
    assign len_bytes             = ADDR_WIDTH'(cur_len) << WSHIFT;
    assign cmd_is_write_not_read = 1'b0;

    alt_vipvfr131_common_credit_counter #(
        .CREDIT_DEPTH (CREDIT_DEPTH),
        .LEN_WIDTH    (BLW),
        .CW           (CW)
    ) u_credit (
        .clock       (clock),
        .reset       (reset),
        .accept      (accept),
        .accept_len  (cur_len),
        .data_read   (data_read),
        .check_len   (nxt_len),
        .outstanding (outstanding),
        .fits        (fits)
    );

    // Region walk: position of the command to present after this edge.
    always_comb begin
        nxt_line_addr  = line_addr;
        nxt_word_addr  = word_addr;
        nxt_words_left = words_left;
        nxt_lines_left = lines_left;
        case (state)
            S_SETUP: begin
                nxt_line_addr  = cfg_base;
                nxt_word_addr  = cfg_base;
                nxt_words_left = cfg_wpl;
                nxt_lines_left = cfg_lines;
            end
            S_ISSUE: begin
                if (accept) begin
                    nxt_word_addr  = word_addr + len_bytes;
                    nxt_words_left = words_left - LINE_WIDTH'(cur_len);
                    if (nxt_words_left == '0) begin
                        nxt_lines_left = lines_left - LINE_WIDTH'(1);
                        nxt_line_addr  = line_addr + cfg_stride;
                        nxt_word_addr  = nxt_line_addr;
                        nxt_words_left = cfg_wpl;
                    end
                end
            end
            default: ;
        endcase
        nxt_len = burst_len(nxt_words_left);
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (go) state_nxt = S_SETUP;
            S_SETUP: state_nxt = ((cfg_wpl == '0) || (cfg_lines == '0)) ? S_DRAIN : S_ISSUE;
            S_ISSUE: if (accept && (nxt_lines_left == '0)) state_nxt = S_DRAIN;
            S_DRAIN: if (outstanding == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: done on the last drain cycle, busy drops with it.
    always_comb begin
        done = (state == S_DRAIN) && (outstanding == '0);
        busy = (state != S_IDLE) && !done;
    end

    // Configuration capture and walk position registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cfg_base   <= '0;
            cfg_stride <= '0;
            cfg_wpl    <= '0;
            cfg_lines  <= '0;
            line_addr  <= '0;
            word_addr  <= '0;
            words_left <= '0;
            lines_left <= '0;
        end else begin
            if ((state == S_IDLE) && go) begin
                cfg_base   <= base_addr;
                cfg_stride <= line_stride;
                cfg_wpl    <= words_per_line;
                cfg_lines  <= num_lines;
            end
            line_addr  <= nxt_line_addr;
            word_addr  <= nxt_word_addr;
            words_left <= nxt_words_left;
            lines_left <= nxt_lines_left;
        end
    end

    // Registered command port; frozen while a presented command is stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_command      <= 1'b0;
            cmd_addr         <= '0;
            cmd_burst_length <= '0;
            cmd_is_burst     <= 1'b0;
        end else if (!(cmd_command && stall)) begin
            cmd_command      <= (state_nxt == S_ISSUE) && fits;
            cmd_addr         <= nxt_word_addr;
            cmd_burst_length <= (state_nxt == S_ISSUE) ? nxt_len : '0;
            cmd_is_burst     <= (state_nxt == S_ISSUE) && (nxt_len > BLW'(1));
        end
    end

endmodule
